conv3x3_sched: RTL

- Sequencing controller for the 3x3 convolution datapath.
- On `start`, walks every output pixel of one feature-map channel in raster order.
- For each pixel, issues the 9 window-tap reads to the feature-map SRAM and drives the MAC tap-valid/pad strobes.
- Inserts the inter-window gap that the downstream 9-tap counter needs, and stalls on result-buffer backpressure.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv3x3_sched_if.sv | 38 +++
 rtl/conv3x3_tap_addr.sv | 37 +++
 rtl/conv3x3_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution scheduler.
//   state_t  : scheduler FSM states
//   TAP_N    : taps per 3x3 window
//   RC_W     : width of the row/column counters and out_row/out_col
//   out_h/w  : output feature-map size for a given input size and padding
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITRDY,
        TAP,
        GAP,
        DONE
    } state_t;

    localparam int unsigned TAP_N = 9;
    localparam int unsigned RC_W  = 8;

    function automatic int unsigned out_h(input int unsigned img_h, input int unsigned pad);
        return img_h - 2 + 2 * pad;
    endfunction

    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned pad);
        return img_w - 2 + 2 * pad;
    endfunction

endpackage

// File: rtl/conv3x3_sched_if.sv
// Handshake / bus bundle of the 3x3 convolution scheduler.
//   start, ofm_rdy            : control inputs to the scheduler
//   busy, done                : frame status
//   fm_rd_en, fm_addr         : feature-map SRAM read port
//   mac_vld, mac_pad, mac_tap : MAC tap strobes, aligned with SRAM read data
//   out_row, out_col          : coordinates of the window in the MAC phase
// Modports: master = scheduler side, slave = environment side.
interface conv3x3_sched_if
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);

    logic              start;
    logic              ofm_rdy;
    logic              busy;
    logic              done;
    logic              fm_rd_en;
    logic [ADDR_W-1:0] fm_addr;
    logic              mac_vld;
    logic              mac_pad;
    logic [3:0]        mac_tap;
    logic [RC_W-1:0]   out_row;
    logic [RC_W-1:0]   out_col;

    modport master (
        input  start, ofm_rdy,
        output busy, done, fm_rd_en, fm_addr,
        output mac_vld, mac_pad, mac_tap, out_row, out_col
    );

    modport slave (
        output start, ofm_rdy,
        input  busy, done, fm_rd_en, fm_addr,
        input  mac_vld, mac_pad, mac_tap, out_row, out_col
    );

endinterface

// File: rtl/conv3x3_tap_addr.sv
// Combinational window-tap address generator.
//   row, col : output-pixel coordinates of the window
//   tap      : tap index 0..8 (dr = tap/3, dc = tap%3)
//   in_range : the tap lands inside the input feature map
//   addr     : SRAM word address r*IMG_W + c (only meaningful when in_range)
module conv3x3_tap_addr
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned PAD    = 1,
    parameter int unsigned ADDR_W = 10
) (
    input  logic [RC_W-1:0]   row,
    input  logic [RC_W-1:0]   col,
    input  logic [3:0]        tap,
    output logic              in_range,
    output logic [ADDR_W-1:0] addr
);

    logic [1:0]             dr;
    logic [1:0]             dc;
    logic signed [RC_W:0]   r;
    logic signed [RC_W:0]   c;

    always_comb begin
        dr = 2'(tap / 4'd3);
        dc = 2'(tap % 4'd3);
        // One extra bit so that coordinate -1 (top/left padding) shows up as negative.
        r = $signed({1'b0, row} + {{(RC_W-1){1'b0}}, dr} - (RC_W+1)'(PAD));
        c = $signed({1'b0, col} + {{(RC_W-1){1'b0}}, dc} - (RC_W+1)'(PAD));
        in_range = !r[RC_W] && (r[RC_W-1:0] < RC_W'(IMG_H)) &&
                   !c[RC_W] && (c[RC_W-1:0] < RC_W'(IMG_W));
        addr = ADDR_W'(r[RC_W-1:0]) * ADDR_W'(IMG_W) + ADDR_W'(c[RC_W-1:0]);
    end

endmodule

// File: rtl/conv3x3_sched.sv
// Sequencing controller for the 3x3 convolution datapath.
// Walks every output pixel of one channel in raster order, issuing the nine
// window-tap SRAM reads per pixel, then one gap cycle so the downstream tap
// counter sees mac_vld drop between windows. Stalls in WAITRDY while the
// result buffer is full.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : conv3x3_sched_if.master (start/ofm_rdy in; status, SRAM
//                read port, MAC strobes and window coordinates out)
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned PAD    = 1,
    parameter int unsigned ADDR_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    conv3x3_sched_if.master bus
);

    localparam int unsigned     OH       = out_h(IMG_H, PAD);
    localparam int unsigned     OW       = out_w(IMG_W, PAD);
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(OH - 1);
    localparam logic [RC_W-1:0] COL_LAST = RC_W'(OW - 1);
    localparam logic [3:0]      TAP_LAST = 4'(TAP_N - 1);

    state_t            state_q, state_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic [3:0]        tap_q, tap_d;

    logic              nxt_in_range;
    logic [ADDR_W-1:0] nxt_addr;

    logic              busy_q;
    logic              done_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              vld_q;
    logic              pad_q;
    logic [3:0]        mtap_q;
    logic [RC_W-1:0]   orow_q;
    logic [RC_W-1:0]   ocol_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_d = '0;
                    col_d = '0;
                    tap_d = '0;
                    // WAITRDY is skipped when ofm_rdy is already high, so tap 0
                    // issues in the cycle right after start.
                    state_d = bus.ofm_rdy ? TAP : WAITRDY;
                end
            end
            WAITRDY: begin
                if (bus.ofm_rdy) begin
                    state_d = TAP;
                    tap_d   = '0;
                end
            end
            TAP: begin
                if (tap_q == TAP_LAST) begin
                    state_d = GAP;
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            GAP: begin
                tap_d = '0;
                if (row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = DONE;
                end else begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                    state_d = bus.ofm_rdy ? TAP : WAITRDY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address of the tap issued next cycle, so the SRAM port can be registered.
    conv3x3_tap_addr #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PAD    (PAD),
        .ADDR_W (ADDR_W)
    ) u_tap_addr (
        .row      (row_d),
        .col      (col_d),
        .tap      (tap_d),
        .in_range (nxt_in_range),
        .addr     (nxt_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
            mtap_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            rd_q    <= (state_d == TAP) && nxt_in_range;
            // Padding taps leave the address bus untouched.
            if ((state_d == TAP) && nxt_in_range) begin
                addr_q <= nxt_addr;
            end
            // MAC strobes trail the SRAM request by the one-cycle read latency.
            vld_q  <= (state_q == TAP);
            pad_q  <= (state_q == TAP) && !rd_q;
            mtap_q <= (state_q == TAP) ? tap_q : '0;
            if (state_q == TAP) begin
                orow_q <= row_q;
                ocol_q <= col_q;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fm_rd_en = rd_q;
    assign bus.fm_addr  = addr_q;
    assign bus.mac_vld  = vld_q;
    assign bus.mac_pad  = pad_q;
    assign bus.mac_tap  = mtap_q;
    assign bus.out_row  = orow_q;
    assign bus.out_col  = ocol_q;

endmodule
